// File: rtl/knn_mem_pkg.sv
// Shared types and constants for the KNN scratch memory: clear-engine states,
// legal read latencies and byte-enable width helper.
package knn_mem_pkg;

  typedef enum logic [0:0] {
    MEM_IDLE,
    MEM_CLEAR
  } mem_state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  function automatic int unsigned BE_W(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/knn_dpram_avmm_if.sv
// One Avalon-MM slave port of the KNN scratch memory.
interface knn_dpram_avmm_if
  import knn_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
);

  logic [ADDR_W-1:0]       address;
  logic [BE_W(DATA_W)-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_W-1:0]       writedata;
  logic [DATA_W-1:0]       readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/knn_dpram_core.sv
// Byte-enabled true-dual-port RAM array with synchronous read and selectable
// mixed-port read-during-write behaviour. Port a wins overlapping lanes.
module knn_dpram_core
  import knn_mem_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 9,
  parameter bit          MIXED_RDW_NEW = 1'b0
) (
  input  logic                    clk,
  input  logic                    we_a,
  input  logic [ADDR_W-1:0]       addr_a,
  input  logic [BE_W(DATA_W)-1:0] be_a,
  input  logic [DATA_W-1:0]       wdata_a,
  output logic [DATA_W-1:0]       rdata_a,
  input  logic                    we_b,
  input  logic [ADDR_W-1:0]       addr_b,
  input  logic [BE_W(DATA_W)-1:0] be_b,
  input  logic [DATA_W-1:0]       wdata_b,
  output logic [DATA_W-1:0]       rdata_b
);

  localparam int unsigned BeW = BE_W(DATA_W);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_a_next;
  logic [DATA_W-1:0] rd_b_next;

  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] new_word,
                                                   input logic [BeW-1:0]    be);
    lane_merge = old_word;
    for (int i = 0; i < int'(BeW); i++) begin
      if (be[i]) lane_merge[8*i +: 8] = new_word[8*i +: 8];
    end
  endfunction

  always_comb begin
    rd_a_next = mem[addr_a];
    rd_b_next = mem[addr_b];
    if (MIXED_RDW_NEW) begin
      if (we_b && (addr_b == addr_a)) rd_a_next = lane_merge(rd_a_next, wdata_b, be_b);
      if (we_a && (addr_a == addr_b)) rd_b_next = lane_merge(rd_b_next, wdata_a, be_a);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(BeW); i++) begin
      if (we_b && be_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
    end
    // Port a is written last so it owns any lane both ports enable.
    for (int i = 0; i < int'(BeW); i++) begin
      if (we_a && be_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
    end
    rdata_a <= rd_a_next;
    rdata_b <= rd_b_next;
  end

endmodule

// File: rtl/knn_dpram_avmm.sv
// Dual Avalon-MM scratch memory shared by Nios (s1) and the KNN pipeline (s2),
// with a clear engine that zeroes the array through port 1.
module knn_dpram_avmm
  import knn_mem_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          MIXED_RDW_NEW  = 1'b0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  knn_dpram_avmm_if.slave         s1,
  knn_dpram_avmm_if.slave         s2,
  input  logic                    clear_req,
  output logic                    clear_busy
);

  localparam int unsigned BeW = BE_W(DATA_W);
  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  mem_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              boot_q;
  logic              clearing;
  logic              waitreq;

  // boot_q lets the post-reset clear begin writing in the very first cycle
  // after reset falls, so the array is clear after exactly DEPTH cycles.
  assign clearing = !reset && ((state_q == MEM_CLEAR) || boot_q);
  assign waitreq  = reset || clearing;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      boot_q  <= CLEAR_ON_RESET;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (boot_q) begin
            state_q <= MEM_CLEAR;
            cnt_q   <= cnt_q + 1'b1;
            boot_q  <= 1'b0;
          end else if (clear_req) begin
            state_q <= MEM_CLEAR;
          end
        end
        MEM_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastAddr) state_q <= MEM_IDLE;
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  logic wr1, rd1, wr2, rd2;

  assign wr1 = s1.chipselect && s1.write && !waitreq;
  assign rd1 = s1.chipselect && s1.read && !s1.write && !waitreq;
  assign wr2 = s2.chipselect && s2.write && !waitreq;
  assign rd2 = s2.chipselect && s2.read && !s2.write && !waitreq;

  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [BeW-1:0]    p1_be;
  logic [DATA_W-1:0] p1_wd;
  logic [BeW-1:0]    p2_be;

  always_comb begin
    p1_we   = clearing || wr1;
    p1_addr = clearing ? cnt_q : s1.address;
    p1_be   = clearing ? {BeW{1'b1}} : s1.byteenable;
    p1_wd   = clearing ? '0 : s1.writedata;
    p2_be   = s2.byteenable;
    // Port 1 owns lanes both ports write to the same word.
    if (p1_we && wr2 && (p1_addr == s2.address)) p2_be = s2.byteenable & ~p1_be;
  end

  logic [DATA_W-1:0] core_q [2];

  knn_dpram_core #(
    .DATA_W        (DATA_W),
    .ADDR_W        (ADDR_W),
    .MIXED_RDW_NEW (MIXED_RDW_NEW)
  ) u_core (
    .clk     (clk),
    .we_a    (p1_we),
    .addr_a  (p1_addr),
    .be_a    (p1_be),
    .wdata_a (p1_wd),
    .rdata_a (core_q[0]),
    .we_b    (wr2),
    .addr_b  (s2.address),
    .be_b    (p2_be),
    .wdata_b (s2.writedata),
    .rdata_b (core_q[1])
  );

  logic [1:0]        v1_q;
  logic [1:0]        out_valid;
  logic [DATA_W-1:0] out_data [2];

  always_ff @(posedge clk) begin
    if (reset) v1_q <= '0;
    else       v1_q <= {rd2, rd1};
  end

  if (READ_LATENCY >= RD_LAT_MAX) begin : g_lat2
    logic [1:0]        v2_q;
    logic [DATA_W-1:0] d2_q [2];

    always_ff @(posedge clk) begin
      if (reset) begin
        v2_q <= '0;
        d2_q <= '{default: '0};
      end else begin
        v2_q <= v1_q;
        for (int p = 0; p < 2; p++) begin
          if (v1_q[p]) d2_q[p] <= core_q[p];
        end
      end
    end

    always_comb begin
      out_valid = v2_q;
      out_data  = d2_q;
    end
  end else begin : g_lat1
    logic [DATA_W-1:0] hold_q [2];

    always_ff @(posedge clk) begin
      if (reset) begin
        hold_q <= '{default: '0};
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (v1_q[p]) hold_q[p] <= core_q[p];
        end
      end
    end

    // The array output moves every cycle; show it only on the response cycle.
    always_comb begin
      out_valid = v1_q;
      for (int p = 0; p < 2; p++) out_data[p] = v1_q[p] ? core_q[p] : hold_q[p];
    end
  end

  assign s1.readdata      = out_data[0];
  assign s1.readdatavalid = out_valid[0];
  assign s1.waitrequest   = waitreq;
  assign s2.readdata      = out_data[1];
  assign s2.readdatavalid = out_valid[1];
  assign s2.waitrequest   = waitreq;
  assign clear_busy       = clearing;

endmodule

// File: tb/tb_knn_dpram_avmm.sv
// Bench for knn_dpram_avmm: two instances (latency 1/old-data and latency 2/new-data)
// share stimulus and are checked against an array model of the memory.
module tb_knn_dpram_avmm;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, clear_req, busy_a, busy_b;
  logic s1_cs, s1_rd, s1_wr, s2_cs, s2_rd, s2_wr;
  logic [AW-1:0] s1_addr, s2_addr;
  logic [3:0] s1_be, s2_be;
  logic [DW-1:0] s1_wd, s2_wd;

  knn_dpram_avmm_if #(.DATA_W(DW), .ADDR_W(AW)) a1 ();
  knn_dpram_avmm_if #(.DATA_W(DW), .ADDR_W(AW)) a2 ();
  knn_dpram_avmm_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
  knn_dpram_avmm_if #(.DATA_W(DW), .ADDR_W(AW)) b2 ();

  assign a1.chipselect = s1_cs;  assign b1.chipselect = s1_cs;
  assign a1.read = s1_rd;        assign b1.read = s1_rd;
  assign a1.write = s1_wr;       assign b1.write = s1_wr;
  assign a1.address = s1_addr;   assign b1.address = s1_addr;
  assign a1.byteenable = s1_be;  assign b1.byteenable = s1_be;
  assign a1.writedata = s1_wd;   assign b1.writedata = s1_wd;
  assign a2.chipselect = s2_cs;  assign b2.chipselect = s2_cs;
  assign a2.read = s2_rd;        assign b2.read = s2_rd;
  assign a2.write = s2_wr;       assign b2.write = s2_wr;
  assign a2.address = s2_addr;   assign b2.address = s2_addr;
  assign a2.byteenable = s2_be;  assign b2.byteenable = s2_be;
  assign a2.writedata = s2_wd;   assign b2.writedata = s2_wd;

  knn_dpram_avmm #(
    .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .MIXED_RDW_NEW(1'b0), .CLEAR_ON_RESET(1'b1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .s1(a1), .s2(a2), .clear_req(clear_req), .clear_busy(busy_a)
  );

  knn_dpram_avmm #(
    .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .MIXED_RDW_NEW(1'b1), .CLEAR_ON_RESET(1'b1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .s1(b1), .s2(b2), .clear_req(clear_req), .clear_busy(busy_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } resp_t;

  typedef struct {
    bit            cs, rd, wr;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wd;
  } op_t;

  // Queue index: 0 = a.s1, 1 = a.s2, 2 = b.s1, 3 = b.s2
  resp_t exp_q [4][$];
  resp_t obs_q [4][$];
  logic [DW-1:0] mem_m [DEPTH];
  int n_checks = 0;
  int n_err    = 0;

  always @(negedge clk) begin
    resp_t r;
    r.cyc = cyc;
    if (a1.readdatavalid === 1'b1) begin r.data = a1.readdata; obs_q[0].push_back(r); end
    if (a2.readdatavalid === 1'b1) begin r.data = a2.readdata; obs_q[1].push_back(r); end
    if (b1.readdatavalid === 1'b1) begin r.data = b1.readdata; obs_q[2].push_back(r); end
    if (b2.readdatavalid === 1'b1) begin r.data = b2.readdata; obs_q[3].push_back(r); end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] apply_be(input logic [DW-1:0] old_w,
                                             input logic [DW-1:0] new_w, input logic [3:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic op_t nop();
    op_t o;
    o.cs = 0; o.rd = 0; o.wr = 0; o.addr = '0; o.be = '0; o.wd = '0;
    return o;
  endfunction

  function automatic op_t rd_op(input int addr);
    op_t o;
    o = nop(); o.cs = 1; o.rd = 1; o.addr = AW'(addr);
    return o;
  endfunction

  function automatic op_t wr_op(input int addr, input logic [3:0] be, input logic [DW-1:0] wd);
    op_t o;
    o = nop(); o.cs = 1; o.wr = 1; o.addr = AW'(addr); o.be = be; o.wd = wd;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int k;
    k      = int'($urandom_range(0, 3));
    o.cs   = ($urandom_range(0, 7) != 0);
    o.rd   = k[0];
    o.wr   = k[1];
    o.addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 15));
    o.be   = 4'($urandom_range(0, 15));
    o.wd   = $urandom;
    return o;
  endfunction

  task automatic push_exp(input int k, input int c, input logic [DW-1:0] d);
    resp_t r;
    r.cyc = c; r.data = d;
    exp_q[k].push_back(r);
  endtask

  // Present one cycle of traffic (memory assumed ready) and update the model.
  task automatic run_cycle(input op_t o1, input op_t o2);
    logic [DW-1:0] pre [DEPTH];
    s1_cs = o1.cs; s1_rd = o1.rd; s1_wr = o1.wr; s1_addr = o1.addr; s1_be = o1.be; s1_wd = o1.wd;
    s2_cs = o2.cs; s2_rd = o2.rd; s2_wr = o2.wr; s2_addr = o2.addr; s2_be = o2.be; s2_wd = o2.wd;
    pre = mem_m;
    if (o2.cs && o2.wr) mem_m[o2.addr] = apply_be(mem_m[o2.addr], o2.wd, o2.be);
    if (o1.cs && o1.wr) mem_m[o1.addr] = apply_be(mem_m[o1.addr], o1.wd, o1.be);
    if (o1.cs && o1.rd && !o1.wr) begin
      push_exp(0, cyc + 1, pre[o1.addr]);
      push_exp(2, cyc + 2, mem_m[o1.addr]);
    end
    if (o2.cs && o2.rd && !o2.wr) begin
      push_exp(1, cyc + 1, pre[o2.addr]);
      push_exp(3, cyc + 2, mem_m[o2.addr]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(nop(), nop());
  endtask

  task automatic check_resp(input string tag);
    string pn [4] = '{"a.s1", "a.s2", "b.s1", "b.s2"};
    int n;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s %s count", tag, pn[k]), 64'(obs_q[k].size()), 64'(exp_q[k].size()));
      n = (obs_q[k].size() < exp_q[k].size()) ? obs_q[k].size() : exp_q[k].size();
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s %s resp%0d {cyc,data}", tag, pn[k], i),
            {32'(obs_q[k][i].cyc), obs_q[k][i].data}, {32'(exp_q[k][i].cyc), exp_q[k][i].data});
      end
      obs_q[k].delete();
      exp_q[k].delete();
    end
  endtask

  // Starts sampling in the first cycle after reset falls; counts until ready.
  task automatic count_clear(input string tag);
    int nw_a = 0, nb_a = 0, nw_b = 0, nb_b = 0, t = 0;
    while ((a1.waitrequest !== 1'b0 || b1.waitrequest !== 1'b0) && t < 200) begin
      if (a1.waitrequest === 1'b1) nw_a++;
      if (b1.waitrequest === 1'b1) nw_b++;
      if (busy_a === 1'b1) nb_a++;
      if (busy_b === 1'b1) nb_b++;
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, " a wait cycles"}, 64'(nw_a), 64'(DEPTH));
    chk({tag, " b wait cycles"}, 64'(nw_b), 64'(DEPTH));
    chk({tag, " a busy cycles"}, 64'(nb_a), 64'(DEPTH));
    chk({tag, " b busy cycles"}, 64'(nb_b), 64'(DEPTH));
    chk({tag, " a.s2 ready"}, 64'(a2.waitrequest), 64'(0));
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  task automatic sweep_all(input string tag);
    for (int i = 0; i < DEPTH; i++) run_cycle(rd_op(i), rd_op(DEPTH - 1 - i));
    idle(3);
    check_resp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_order [4] = '{0, 7, 3, 5};
    reset = 1'b1;
    clear_req = 1'b0;
    s1_cs = 0; s1_rd = 0; s1_wr = 0; s1_addr = '0; s1_be = '0; s1_wd = '0;
    s2_cs = 0; s2_rd = 0; s2_wr = 0; s2_addr = '0; s2_be = '0; s2_wd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset a.s1 wait", 64'(a1.waitrequest), 64'(1));
    chk("reset a.s2 wait", 64'(a2.waitrequest), 64'(1));
    chk("reset b.s1 wait", 64'(b1.waitrequest), 64'(1));
    chk("reset b.s2 wait", 64'(b2.waitrequest), 64'(1));
    chk("reset a.s1 valid", 64'(a1.readdatavalid), 64'(0));
    chk("reset b.s2 valid", 64'(b2.readdatavalid), 64'(0));
    chk("reset a.s1 data", 64'(a1.readdata), 64'(0));
    chk("reset a.s2 data", 64'(a2.readdata), 64'(0));
    chk("reset b.s1 data", 64'(b1.readdata), 64'(0));
    chk("reset b.s2 data", 64'(b2.readdata), 64'(0));
    chk("reset a busy", 64'(busy_a), 64'(0));
    chk("reset b busy", 64'(busy_b), 64'(0));

    reset = 1'b0;
    #1;
    count_clear("boot clear");
    sweep_all("post-boot zero sweep");

    // Byte-lane merge across ports
    run_cycle(wr_op(5, 4'b1111, 32'hDEADBEEF), nop());
    run_cycle(nop(), wr_op(5, 4'b0001, 32'h000000AA));
    run_cycle(rd_op(5), nop());
    // Same-cycle write collision on addr 3
    run_cycle(wr_op(3, 4'b0011, 32'h11111111), wr_op(3, 4'b0110, 32'h22222222));
    run_cycle(rd_op(3), rd_op(3));
    // Mixed-port read during write on addr 7
    run_cycle(wr_op(7, 4'b1111, 32'h5A5A5A5A), rd_op(7));
    run_cycle(rd_op(7), nop());
    idle(3);
    check_resp("directed");

    // Back-to-back reads on s2
    for (int i = 0; i < 4; i++) run_cycle(nop(), rd_op(rd_order[i]));
    idle(4);
    check_resp("back-to-back");
    chk("hold a.s2 data", 64'(a2.readdata), 64'(mem_m[5]));
    chk("hold b.s2 data", 64'(b2.readdata), 64'(mem_m[5]));

    for (int i = 0; i < 300; i++) run_cycle(rand_op(), rand_op());
    idle(3);
    check_resp("random");

    // Clear request with a read in flight, then reset in clear cycle 6
    clear_req = 1'b1;
    run_cycle(nop(), rd_op(5));
    clear_req = 1'b0;
    chk("clear cycle1 a busy", 64'(busy_a), 64'(1));
    chk("clear cycle1 b wait", 64'(b1.waitrequest), 64'(1));
    idle(5);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid-clear reset a busy", 64'(busy_a), 64'(0));
    chk("mid-clear reset b wait", 64'(b2.waitrequest), 64'(1));
    reset = 1'b0;
    #1;
    count_clear("restart clear");
    idle(2);
    check_resp("clear-abort");
    sweep_all("post-restart zero sweep");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
